// File: rtl/simple_proc.sv
// simple_proc: multi-cycle 16-bit processor with a serially loaded 16-entry program memory.
// Optional debug register read port enabled by defining SIMPLE_PROC_DBG_EN.
//
// state | meaning
// IDLE  | waiting for start; program memory accepts writes
// FETCH | end-of-program test, instruction register load
// EXEC  | execute instruction in ir, advance pc
// HALT  | finished; held until start drops
module simple_proc (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        write,
    input  logic [22:0] program_in,
`ifdef SIMPLE_PROC_DBG_EN
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_data,
`endif
    output logic        busy,
    output logic        done,
    output logic [3:0]  pc,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        zero,
    output logic        carry
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_BEQZ = 4'd10;
    localparam logic [3:0] OP_OUT  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_pc;
    logic [4:0]  r_prog_len;
    logic [22:0] r_ir;
    logic [22:0] r_mem [16];
    logic [15:0] r_regs [8];
    logic        r_zero;
    logic        r_carry;
    logic [15:0] r_out_data;
    logic        r_out_valid;
    logic        r_busy;
    logic        r_done;

    logic [3:0]  w_op;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs1;
    logic [2:0]  w_rs2;
    logic [15:0] w_imm;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_d;
    logic [16:0] w_result;
    logic        w_reg_we;
    logic        w_carry_we;
    logic [3:0]  w_pc_next;
    logic        w_fetch_ok;
    logic        w_load;

    assign w_op  = r_ir[22:19];
    assign w_rd  = r_ir[18:16];
    assign w_rs1 = r_ir[15:13];
    assign w_rs2 = r_ir[12:10];
    assign w_imm = r_ir[15:0];
    assign w_a   = r_regs[w_rs1];
    assign w_b   = r_regs[w_rs2];
    assign w_d   = r_regs[w_rd];

    // prog_len is one bit wider than pc so a full 16-word program never ends by length
    assign w_fetch_ok = ({1'b0, r_pc} < r_prog_len);
    assign w_load     = (r_state == S_IDLE) && write && (r_prog_len != 5'd16);

    always_comb begin
        w_result   = 17'd0;
        w_reg_we   = 1'b0;
        w_carry_we = 1'b0;
        w_pc_next  = r_pc + 4'd1;
        case (w_op)
            OP_LDI: begin w_result = {1'b0, w_imm};           w_reg_we = 1'b1; end
            OP_ADD: begin
                w_result   = {1'b0, w_a} + {1'b0, w_b};
                w_reg_we   = 1'b1;
                w_carry_we = 1'b1;
            end
            OP_SUB: begin
                w_result   = {1'b0, w_a} - {1'b0, w_b};
                w_reg_we   = 1'b1;
                w_carry_we = 1'b1;
            end
            OP_AND: begin w_result = {1'b0, w_a & w_b};       w_reg_we = 1'b1; end
            OP_OR:  begin w_result = {1'b0, w_a | w_b};       w_reg_we = 1'b1; end
            OP_XOR: begin w_result = {1'b0, w_a ^ w_b};       w_reg_we = 1'b1; end
            OP_MOV: begin w_result = {1'b0, w_a};             w_reg_we = 1'b1; end
            OP_SHL: begin w_result = {1'b0, w_a[14:0], 1'b0}; w_reg_we = 1'b1; end
            OP_SHR: begin w_result = {2'b00, w_a[15:1]};      w_reg_we = 1'b1; end
            OP_JMP: w_pc_next = w_imm[3:0];
            OP_BEQZ: begin
                if (w_d == 16'd0) w_pc_next = w_imm[3:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_FETCH;
            S_FETCH: w_state_next = w_fetch_ok ? S_EXEC : S_HALT;
            S_EXEC:  w_state_next = (w_op == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:  if (!start) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // busy/done decoded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_FETCH) || (w_state_next == S_EXEC);
            r_done  <= (w_state_next == S_HALT);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc        <= 4'd0;
            r_prog_len  <= 5'd0;
            r_ir        <= 23'd0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_out_data  <= 16'd0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < 8; i++) r_regs[i] <= 16'd0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_load) r_prog_len <= r_prog_len + 5'd1;
            case (r_state)
                S_IDLE:  if (start) r_pc <= 4'd0;
                S_FETCH: if (w_fetch_ok) r_ir <= r_mem[r_pc];
                S_EXEC: begin
                    r_pc <= w_pc_next;
                    if (w_reg_we) begin
                        r_regs[w_rd] <= w_result[15:0];
                        r_zero       <= (w_result[15:0] == 16'd0);
                    end
                    if (w_carry_we) r_carry <= w_result[16];
                    if (w_op == OP_OUT) begin
                        r_out_data  <= w_d;
                        r_out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // program memory is deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (reset && w_load) r_mem[r_prog_len[3:0]] <= program_in;
    end

`ifdef SIMPLE_PROC_DBG_EN
    assign dbg_data = r_regs[dbg_sel];
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign pc        = r_pc;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign zero      = r_zero;
    assign carry     = r_carry;

endmodule

// File: tb/tb_simple_proc.sv
// Bench for simple_proc: directed programs plus random forward-branching programs,
// each checked against an instruction-level reference model.
module tb_simple_proc;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        write;
    logic [22:0] program_in;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [15:0] out_data;
    logic        out_valid;
    logic        zero;
    logic        carry;

    simple_proc dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .write      (write),
        .program_in (program_in),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .zero       (zero),
        .carry      (carry)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // reference model: architectural state, executed one instruction at a time
    int          m_r [8];
    int          m_zero, m_carry, m_pc, m_len, m_cycles;
    logic [22:0] m_mem [16];
    int          m_outs [$];
    logic [22:0] prog [$];

    function automatic logic [22:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 10'd0};
    endfunction

    function automatic logic [22:0] enc_i(input int op, input int rd, input int imm);
        return {op[3:0], rd[2:0], imm[15:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_zero = 0; m_carry = 0; m_pc = 0; m_len = 0;
    endtask

    // m_cycles = cycle index (start edge -> cycle 1) at which done is first seen
    task automatic model_run();
        int steps, op, rd, a, b, imm, res, nxt;
        logic [22:0] w;
        m_outs.delete();
        m_pc = 0; m_cycles = 0; steps = 0;
        forever begin
            if (m_pc >= m_len || steps > 1000) begin m_cycles += 2; break; end
            w = m_mem[m_pc];
            m_cycles += 2; steps++;
            op = int'(w[22:19]); rd = int'(w[18:16]);
            a = m_r[w[15:13]]; b = m_r[w[12:10]]; imm = int'(w[15:0]);
            nxt = (m_pc + 1) % 16;
            res = -1;
            case (op)
                0: res = imm;
                1: begin res = (a + b) % 65536; m_carry = (a + b) / 65536; end
                2: begin res = (a - b + 65536) % 65536; m_carry = (a < b) ? 1 : 0; end
                3: res = a & b;
                4: res = a | b;
                5: res = a ^ b;
                6: res = a;
                7: res = (a * 2) % 65536;
                8: res = a / 2;
                9: nxt = imm % 16;
                10: if (m_r[rd] == 0) nxt = imm % 16;
                11: m_outs.push_back(m_r[rd]);
                default: ;
            endcase
            if (res >= 0) begin m_r[rd] = res; m_zero = (res == 0) ? 1 : 0; end
            m_pc = nxt;
            if (op == 15) begin m_cycles += 1; break; end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic load_words(input bit with_start);
        for (int i = 0; i < prog.size(); i++) begin
            program_in = prog[i];
            write = 1'b1;
            if (with_start && i == prog.size() - 1) start = 1'b1;
            @(posedge clk); #1;
            if (m_len < 16) begin m_mem[m_len] = prog[i]; m_len++; end
        end
        write = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
    endtask

    // called #1 after the edge that sampled start
    task automatic observe(input string tag, input bit hold);
        int cyc;
        int got [$];
        if (!hold) start = 1'b0;
        cyc = 1;
        chk({tag, ".busy_run"}, busy, 1);
        model_run();
        while (!done && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid) got.push_back(int'(out_data));
        end
        chk({tag, ".done_cycle"}, cyc, m_cycles);
        chk({tag, ".out_count"}, got.size(), m_outs.size());
        for (int i = 0; i < got.size() && i < m_outs.size(); i++)
            chk($sformatf("%s.out%0d", tag, i), got[i], m_outs[i]);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".zero"}, zero, m_zero);
        chk({tag, ".carry"}, carry, m_carry);
        chk({tag, ".busy_halt"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; write = 1'b0; program_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.pc", pc, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.zero", zero, 0);
        chk("rst.carry", carry, 0);
        reset = 1'b1;
        model_reset();

        // single LDI, then append OUT r0 and rerun to expose r0
        prog = '{enc_i(0, 0, 1)};
        load_words(0);
        pulse_start();
        observe("t1", 0);
        chk("t1.pc_const", pc, 1);
        @(posedge clk); #1;
        prog = '{enc_r(11, 0, 0, 0)};
        load_words(0);
        pulse_start();
        observe("t1b", 0);

        // ADD overflow
        do_reset();
        prog = '{enc_i(0, 1, 16'hFFFF), enc_i(0, 2, 1), enc_r(1, 3, 1, 2),
                 enc_r(11, 3, 0, 0), enc_r(15, 0, 0, 0)};
        load_words(0);
        pulse_start();
        observe("t2", 0);
        chk("t2.carry_const", carry, 1);
        chk("t2.zero_const", zero, 1);
        chk("t2.out_data_const", out_data, 0);
        @(posedge clk); #1;

        // countdown loop
        do_reset();
        prog = '{enc_i(0, 0, 3), enc_i(0, 1, 1), enc_r(2, 0, 0, 1), enc_i(10, 0, 5),
                 enc_i(9, 0, 2), enc_r(11, 0, 0, 0), enc_r(15, 0, 0, 0)};
        load_words(0);
        pulse_start();
        observe("t3", 0);
        @(posedge clk); #1;

        // 17 writes, last one together with start; hold start afterwards
        do_reset();
        prog.delete();
        for (int i = 0; i < 7; i++) prog.push_back(enc_i(0, i, int'($urandom_range(1, 65535))));
        for (int i = 0; i < 8; i++) prog.push_back(enc_r(11, i, 0, 0));
        prog.push_back(enc_r(15, 0, 0, 0));
        prog.push_back(enc_i(0, 0, 16'h1234));
        load_words(1);
        observe("t4", 1);
        chk("t4.pc_wrap", pc, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold.done", done, 1);
        start = 1'b0;
        @(posedge clk); #1;
        chk("hold.idle_done", done, 0);
        chk("hold.idle_busy", busy, 0);
        pulse_start();
        observe("rerun", 0);
        @(posedge clk); #1;

        // reset in the middle of a run
        do_reset();
        prog = '{enc_i(0, 0, 3), enc_i(0, 1, 1), enc_r(2, 0, 0, 1), enc_i(10, 0, 5),
                 enc_i(9, 0, 2), enc_r(11, 0, 0, 0), enc_r(15, 0, 0, 0)};
        load_words(0);
        pulse_start();
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.pc", pc, 0);
        chk("midrst.zero", zero, 0);
        chk("midrst.carry", carry, 0);
        reset = 1'b1;
        model_reset();
        prog.delete();
        for (int i = 0; i < 8; i++) prog.push_back(enc_r(11, i, 0, 0));
        load_words(0);
        pulse_start();
        observe("midrst_regs", 0);
        @(posedge clk); #1;

        // random forward-branching programs
        for (int t = 0; t < 25; t++) begin
            int n, op, val;
            do_reset();
            prog.delete();
            n = int'($urandom_range(0, 7));
            for (int i = 0; i < n; i++) begin
                op  = int'($urandom_range(0, 15));
                if (op == 9 || op == 10) begin
                    prog.push_back(enc_i(op, int'($urandom_range(0, 7)), int'($urandom_range(i + 1, 15))));
                end else if (op == 0) begin
                    case ($urandom_range(0, 3))
                        0: val = 0;
                        1: val = 16'hFFFF;
                        default: val = int'($urandom_range(0, 65535));
                    endcase
                    prog.push_back(enc_i(0, int'($urandom_range(0, 7)), val));
                end else begin
                    prog.push_back(enc_r(op, int'($urandom_range(0, 7)),
                                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
                end
            end
            for (int i = 0; i < 8; i++) prog.push_back(enc_r(11, i, 0, 0));
            if ($urandom_range(0, 1) == 1) begin
                load_words(1);
            end else begin
                load_words(0);
                pulse_start();
            end
            observe($sformatf("rnd%0d", t), 0);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simple_proc.md
# simple_proc

Minimal multi-cycle 16-bit processor with an internal 16-entry program memory loaded serially over `program_in`/`write`. It executes from address 0 once `start` is seen and runs to a HALT instruction or the end of the loaded program. It is the standalone compute block: host-side logic loads a program, pulses `start`, then watches `done` and the output port.

## Interface
Parameters: none. Widths are fixed: 23-bit instruction, 8 × 16-bit registers, 16-entry program memory.
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; clock clk
- start  in  1  run request, sampled only in IDLE
- write  in  1  append `program_in` to program memory (IDLE only)
- program_in  in  23  instruction word to load
- busy  out  1  high in FETCH/EXEC
- done  out  1  high in HALT
- pc  out  4  current program counter
- out_data  out  16  last value sent by OUT
- out_valid  out  1  one-cycle pulse when `out_data` updates
- zero  out  1  last ALU result was 0
- carry  out  1  carry/borrow of last ADD/SUB

## Operation
- Instruction fields: opcode [22:19], rd [18:16], rs1 [15:13], rs2 [12:10], imm [15:0]. Jump target is imm[3:0].
- Opcodes:
  - 0 LDI: rd←imm.
  - 1 ADD: rd←rs1+rs2.
  - 2 SUB: rd←rs1−rs2.
  - 3 AND, 4 OR, 5 XOR: bitwise on rs1, rs2.
  - 6 MOV: rd←rs1.
  - 7 SHL: rd←rs1<<1.
  - 8 SHR: rd←rs1>>1, logical.
  - 9 JMP: pc←imm[3:0].
  - 10 BEQZ: if r[rd]==0, pc←imm[3:0].
  - 11 OUT: out_data←r[rd], out_valid pulses.
  - 15 HALT.
  - 12–14: NOP.
- Arithmetic is modulo 2^16.
  - ADD: carry = bit 16 of the sum.
  - SUB: carry = 1 when a borrow occurred (rs1 < rs2).
- `zero` updates on opcodes 0–8. `carry` updates only on ADD/SUB. All other opcodes leave both flags unchanged.
- Non-branch instructions increment pc by 1, mod 16.
- Loading program memory:
  - `prog_len` (0–16, internal) counts words loaded.
  - In IDLE, `write=1` stores `program_in` at mem[prog_len] and increments `prog_len`.
  - Writes are ignored when `prog_len`==16 and outside IDLE.
- State machine:
  - IDLE: `start=1` → FETCH with pc←0.
  - FETCH: if pc ≥ prog_len → HALT; otherwise ir←mem[pc] → EXEC.
  - EXEC: execute the instruction. HALT opcode → HALT; otherwise → FETCH.
  - HALT: when `start=0` → IDLE. Registers, flags and `prog_len` are retained, so the program can be rerun.
- `start` deasserting mid-run does not stop execution.
- `write` and `start` both high in IDLE: the write is performed and the run starts. The new `prog_len` is visible at the first FETCH.
- Reset mid-operation aborts the run immediately and returns to IDLE.

## Timing
- Reset values: state=IDLE, pc=0, prog_len=0, r0–r7=0, zero=0, carry=0, out_data=0, out_valid=0, busy=0, done=0. Memory contents are not cleared.
- Each instruction takes 2 cycles (FETCH + EXEC). Register and flag results are visible the cycle after EXEC.
- Cycle-level sequence:
  - `start` sampled at edge N → FETCH in cycle N+1.
  - First EXEC in cycle N+2.
  - End-of-program FETCH → HALT one cycle later; `done` rises.
- With prog_len=0: start → FETCH → HALT, so `done` is high 2 cycles after start.
- `out_valid` is high for exactly the cycle after the EXEC of an OUT.
- `busy` and `done` are registered decodes of the state.

## Configuration
- `SIMPLE_PROC_DBG_EN` defined:
  - Adds input `dbg_sel[2:0]` and output `dbg_data[15:0]`.
  - `dbg_data` is a combinational read of r[dbg_sel].
- Undefined: those ports do not exist. Core behaviour is identical either way.

## Test plan
- Reset, then write 0x000001 and start: FETCH/EXEC/FETCH/HALT; r0=1, zero=0, `done` high 4 cycles after start is sampled; pc=1.
- Load LDI r1,0xFFFF; LDI r2,1; ADD r3,r1,r2; OUT r3; HALT: out_data=0, out_valid one pulse, zero=1, carry=1.
- Load LDI r0,3; SUB r0,r0,r1 (r1=1 via LDI); BEQZ r0,→end; JMP back: loop exits after 3 iterations; final r0=0.
- Write 17 words: the 17th is ignored, prog_len=16; program runs through pc 15 then halts with pc=0 (wrap).
- Assert reset low mid-run: next cycle state IDLE, pc=0, busy=0, done=0, all registers 0.
- Hold `start` high after HALT: stays in HALT. Drop `start`, then re-pulse it: reruns the same program with identical outputs.
